// File: rtl/prio_code_decoder_pkg.sv
// Shared types, widths and the code-to-line helper for the priority-code decoder.
package prio_code_pkg;

  localparam int CODE_W = 3;
  localparam int LINE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } pcd_state_t;

  // Encoder codes are active-low, so the line index is the inverted code.
  function automatic logic [LINE_W-1:0] code2line_n(input logic [CODE_W-1:0] y_n);
    logic [CODE_W-1:0] idx;
    idx = ~y_n;
    return ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/prio_code_decoder_if.sv
// Request/response bundle between the priority encoder side and the decoder.
interface prio_code_decoder_if;
  import prio_code_pkg::*;

  logic              en_in_n;
  logic [CODE_W-1:0] y_n;
  logic              gs_n;
  logic              ready;
  logic [LINE_W-1:0] d_n;
  logic              busy;
  logic              done;
  logic [7:0]        count;

  modport master (
    output en_in_n, y_n, gs_n,
    input  ready, d_n, busy, done, count
  );

  modport slave (
    input  en_in_n, y_n, gs_n,
    output ready, d_n, busy, done, count
  );
endinterface

// File: rtl/prio_code_decoder_timer.sv
// Loadable 8-bit down-counter shared by the hold and gap phases.
module pcd_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] value,
  output logic       expired
);

  logic [7:0] cnt_r;

  // Load has priority over counting; the count parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (clr) begin
      cnt_r <= 8'd0;
    end else if (load) begin
      cnt_r <= value;
    end else if (cnt_r != 8'd0) begin
      cnt_r <= cnt_r - 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A phase loaded with N ends on the Nth edge after the load edge.
  assign expired = (cnt_r <= 8'd1);

endmodule

// File: rtl/prio_code_decoder.sv
// Sequential 3-to-8 decoder with programmable hold/gap and a one-entry pending slot.
module prio_code_decoder
  import prio_code_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  prio_code_decoder_if.slave  bus
);

  localparam logic       HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [7:0] HOLD_VAL = 8'(HOLD_CYCLES);
  localparam logic [7:0] GAP_VAL  = 8'(GAP_CYCLES);

  pcd_state_t        state_r, nxt_state_s;
  logic [LINE_W-1:0] d_n_r, nxt_d_n_s;
  logic              done_r, nxt_done_s;
  logic [7:0]        count_r;
  logic              pend_valid_r, nxt_pend_valid_s;
  logic [CODE_W-1:0] pend_code_r, nxt_pend_code_s;
  logic              ready_s, acc_s;
  logic              tmr_clr_s, tmr_load_s, tmr_expired_s;
  logic [7:0]        tmr_val_s;

  assign ready_s = rst_n & ~bus.en_in_n & ~pend_valid_r;
  assign acc_s   = ~bus.gs_n & ~bus.en_in_n & ready_s;

  pcd_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr_s),
    .load    (tmr_load_s),
    .value   (tmr_val_s),
    .expired (tmr_expired_s)
  );

  // Next-state, next-output and timer control.
  always_comb begin
    nxt_state_s      = state_r;
    nxt_d_n_s        = d_n_r;
    nxt_done_s       = 1'b0;
    nxt_pend_valid_s = pend_valid_r;
    nxt_pend_code_s  = pend_code_r;
    tmr_clr_s        = 1'b0;
    tmr_load_s       = 1'b0;
    tmr_val_s        = HOLD_VAL;
    if (bus.en_in_n) begin
      nxt_state_s      = IDLE;
      nxt_d_n_s        = 8'hFF;
      nxt_pend_valid_s = 1'b0;
      tmr_clr_s        = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (acc_s) begin
            nxt_state_s = DRIVE;
            nxt_d_n_s   = code2line_n(bus.y_n);
            tmr_load_s  = 1'b1;
          end else begin
            nxt_d_n_s = 8'hFF;
          end
        end
        DRIVE, GAP: begin
          if (acc_s) begin
            nxt_pend_valid_s = 1'b1;
            nxt_pend_code_s  = bus.y_n;
          end else begin
            nxt_pend_valid_s = pend_valid_r;
          end
          if (tmr_expired_s) begin
            nxt_done_s = (state_r == DRIVE);
            if ((state_r == DRIVE) && HAS_GAP) begin
              nxt_state_s = GAP;
              nxt_d_n_s   = 8'hFF;
              tmr_load_s  = 1'b1;
              tmr_val_s   = GAP_VAL;
            end else if (pend_valid_r) begin
              nxt_state_s      = DRIVE;
              nxt_d_n_s        = code2line_n(pend_code_r);
              nxt_pend_valid_s = 1'b0;
              tmr_load_s       = 1'b1;
            end else if (acc_s) begin
              // A code arriving on the very edge the phase ends goes straight to DRIVE.
              nxt_state_s      = DRIVE;
              nxt_d_n_s        = code2line_n(bus.y_n);
              nxt_pend_valid_s = 1'b0;
              tmr_load_s       = 1'b1;
            end else begin
              nxt_state_s = IDLE;
              nxt_d_n_s   = 8'hFF;
            end
          end else begin
            nxt_state_s = state_r;
          end
        end
        default: begin
          nxt_state_s      = IDLE;
          nxt_d_n_s        = 8'hFF;
          nxt_pend_valid_s = 1'b0;
          tmr_clr_s        = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      d_n_r        <= 8'hFF;
      done_r       <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_code_r  <= 3'd0;
    end else begin
      state_r      <= nxt_state_s;
      d_n_r        <= nxt_d_n_s;
      done_r       <= nxt_done_s;
      pend_valid_r <= nxt_pend_valid_s;
      pend_code_r  <= nxt_pend_code_s;
    end
  end

  // Accepted-code counter; survives aborts and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 8'd0;
    end else if (acc_s) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.ready = ready_s;
  assign bus.d_n   = d_n_r;
  assign bus.done  = done_r;
  assign bus.count = count_r;
  assign bus.busy  = (state_r != IDLE) | pend_valid_r;

endmodule
